mux_rr_nx1_reg: RTL and testbench
=================================

Name: mux_rr_nx1_reg

Overview:
- Parametrised N-channel, W-bit selector. Successor to the combinational 2x1/32x1 mux family.
- Adds a registered output stage and per-channel valid/ready handshakes.
- Two modes: direct select (SEL-driven) and round-robin arbitration.
- Used wherever several datapath sources share one sink under backpressure, e.g. register-file write-back sources or memory-request sources.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 32, number of input channels; legal range 2..2^SEL_W.
- SEL_W, 5, width of SEL and OUT_CH.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- MODE  in  1  0 = direct select, 1 = round-robin.
- SEL  in  SEL_W  channel index, used in direct mode only.
- IN_DATA  in  NUM_CH*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- IN_VALID  in  NUM_CH  per-channel valid.
- IN_READY  out  NUM_CH  per-channel ready; at most one bit set.
- OUT_DATA  out  WIDTH  registered selected data.
- OUT_CH  out  SEL_W  index of the channel that produced OUT_DATA.
- OUT_VALID  out  1  output register holds data.
- OUT_READY  in  1  sink accepts OUT_DATA this cycle.
- SEL_ERR  out  1  combinational: MODE=0 and SEL>=NUM_CH.

Behaviour:
- Reset (async assert, sync release):
  - OUT_VALID=0, OUT_DATA=0, OUT_CH=0, round-robin pointer PTR=0.
  - IN_READY forced to all-zero while RST=1.
- Load enable: LD = !OUT_VALID || OUT_READY.
- Grant in direct mode (MODE=0):
  - g=SEL if SEL<NUM_CH and IN_VALID[SEL]=1; otherwise no grant.
  - SEL>=NUM_CH: no grant, SEL_ERR=1, no input consumed.
  - PTR unchanged.
- Grant in round-robin mode (MODE=1):
  - g = first i with IN_VALID[i]=1, scanning PTR, PTR+1, ..., NUM_CH-1, 0, ..., PTR-1.
  - No valid input: no grant.
- IN_READY[g] = LD when a grant exists; all other bits 0. IN_READY may depend combinationally on IN_VALID, MODE, SEL and OUT_READY.
- Transfer: occurs when IN_VALID[g] && IN_READY[g]. On that edge:
  - OUT_DATA <= channel g data, OUT_CH <= g, OUT_VALID <= 1.
  - In round-robin mode, PTR <= (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- LD=1 with no grant: OUT_VALID <= 0. OUT_DATA and OUT_CH keep their old values.
- Hold: while OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_CH and OUT_VALID are stable and no IN_READY is asserted.
- Latency and throughput:
  - One cycle from input transfer to OUT_VALID.
  - Full throughput of 1 word/cycle while OUT_READY=1 (simultaneous drain and load in the same cycle).
- MODE/SEL changes take effect on the next grant evaluation and never disturb a held output. PTR is retained across direct-mode intervals.
- Reset asserted mid-hold: the output word is discarded and OUT_VALID=0 immediately (async). After release, the first round-robin scan starts at channel 0.
- Combinational loops: none from OUT_* to IN_READY other than through OUT_READY.

Test Plan:
- Direct basic:
  - Setup: NUM_CH=32, channel i data = {10,11,...,19,110..119,210..219,310,311}, all IN_VALID=1, OUT_READY=1, MODE=0.
  - Stimulus: step SEL 0..31 one per cycle.
  - Required: each cycle after SEL=k, OUT_DATA = channel k value, OUT_CH=k, OUT_VALID=1. Specifically SEL=3 -> 13 and SEL=31 -> 311.
- Backpressure:
  - Stimulus: MODE=0, SEL=5, transfer 15; OUT_READY=0 for 4 cycles while channel 5 data changes to 99.
  - Required: OUT_DATA stays 15, IN_READY=0.
  - Then OUT_READY=1: 99 appears on the next cycle.
- Round-robin fairness:
  - Stimulus: MODE=1, all 32 valid, OUT_READY=1.
  - Required: OUT_CH sequence 0,1,...,31,0 with no repeats before wrap.
  - Second stimulus: only channels 2 and 5 valid, PTR=3.
  - Required: grant order 5, 2, 5, 2.
- Out-of-range select:
  - Stimulus: NUM_CH=20, MODE=0, SEL=25, all valid.
  - Required: SEL_ERR=1, IN_READY=0, OUT_VALID drops to 0 after the pending word drains.
- Reset mid-operation:
  - Stimulus: MODE=1, PTR=7, OUT_VALID=1 held by OUT_READY=0; assert RST between edges.
  - Required: OUT_VALID=0 and OUT_DATA=0 immediately.
  - After release with all channels valid, first OUT_CH=0.
- Mode switch:
  - Stimulus: round-robin until PTR=4; MODE=0, SEL=9 for 2 transfers; back to MODE=1.
  - Required: OUT_CH sequence 9, 9, then 4.

Source files
------------

// File: rtl/mux_rr_nx1_reg.sv
// ----------------------------------------------------------------------------
// mux_rr_nx1_reg
//
// Parametrised NUM_CH-input, WIDTH-bit selector with a registered output
// stage and per-channel valid/ready handshakes. It has two grant modes:
//   mode = 0 : direct select, where channel `sel` is granted when it is valid.
//   mode = 1 : round-robin, which scans from ptr_q upward and wraps to 0.
// The output register reloads whenever it is empty or being drained
// (ld = !out_valid || out_ready). This gives one word per cycle under
// continuous out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (released synchronously)
//   mode       0 = direct select, 1 = round-robin
//   sel        channel index used in direct mode
//   in_data    flattened inputs; channel i is in_data[i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit set, zero during reset
//   out_data   registered data of the granted channel
//   out_ch     index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  sink accepts out_data this cycle
//   sel_err    combinational: mode = 0 and sel >= NUM_CH
// ----------------------------------------------------------------------------
module mux_rr_nx1_reg #(
   parameter int WIDTH  = 32,
   parameter int NUM_CH = 32,
   parameter int SEL_W  = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_ch,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err
);

   // NUM_CH may equal 2**SEL_W, so the compare needs one extra bit.
   localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_ch_q,    out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   logic             ld;
   logic             sel_in_range;
   logic             dir_vld;
   logic             hi_vld, lo_vld, rr_vld;
   logic [SEL_W-1:0] hi_idx, lo_idx, rr_idx;
   logic             grant_vld;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;

   assign ld           = !out_valid_q || out_ready;
   assign sel_in_range = {1'b0, sel} < NUM_CH_W;
   assign sel_err      = !mode && !sel_in_range;

   // Direct mode: look up the valid bit of the selected channel. An
   // out-of-range sel matches no channel and therefore never grants.
   // NOTE: every always_comb output gets a default before any branch; a path
   // that leaves a signal unassigned would infer a latch.
   always_comb begin
      dir_vld = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sel == SEL_W'(i)) dir_vld = in_valid[i];
      end
   end

   // Round-robin: split the ring at ptr_q. The lowest valid index at or above
   // ptr_q wins (hi). If there is none, the lowest valid index below ptr_q
   // wins (lo). The loop runs downward so that the last match is the lowest.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            if (SEL_W'(i) >= ptr_q) begin
               hi_vld = 1'b1;
               hi_idx = SEL_W'(i);
            end else begin
               lo_vld = 1'b1;
               lo_idx = SEL_W'(i);
            end
         end
      end
   end

   assign rr_vld    = hi_vld || lo_vld;
   assign rr_idx    = hi_vld ? hi_idx : lo_idx;
   assign grant_vld = mode ? rr_vld : (sel_in_range && dir_vld);
   assign grant_idx = mode ? rr_idx : sel;

   // One-hot ready and data mux for the granted channel. Ready is also gated
   // by rst so that no source believes it was consumed while in reset.
   always_comb begin
      in_ready   = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_idx == SEL_W'(i)) begin
            in_ready[i] = !rst && grant_vld && ld;
            grant_data  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state logic. With ld=1 a grant always transfers, because a grant
   // implies in_valid[g] and in_ready[g] = ld.
   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (ld) begin
         if (grant_vld) begin
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (mode) ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + SEL_W'(1);
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // NOTE: the data and channel registers are reset along with the valid bit,
   // because the sink is allowed to observe out_data and out_ch while
   // out_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments; each flop samples its _d value at
         // the same edge regardless of statement order.
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_nx1_reg.sv
// ----------------------------------------------------------------------------
// tb_mux_rr_nx1_reg
//
// Self-checking bench for mux_rr_nx1_reg.
//
// The main instance uses NUM_CH=32. A second instance with NUM_CH=20
// exercises out-of-range select.
//
// At each falling edge, a reference model predicts the grant from the driven
// inputs and its own pointer. Every predicted transfer is pushed into a
// scoreboard queue. The word at the head of the queue must be the word
// presented on out_*. It is popped, and recorded in a log, when the sink
// accepts it. Each scenario then checks the log against fixed sequences.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_rr_nx1_reg;

   localparam int W   = 32;
   localparam int N   = 32;
   localparam int SW  = 5;
   localparam int N20 = 20;

   typedef struct {
      int          ch;
      logic [31:0] data;
   } word_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance
   logic          mode;
   logic [SW-1:0] sel;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_valid, in_ready;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_ch;
   logic          out_valid, out_ready, sel_err;

   // NUM_CH=20 instance
   logic [SW-1:0]    sel20;
   logic [N20*W-1:0] in_data20;
   logic [N20-1:0]   in_valid20, in_ready20;
   logic [W-1:0]     out_data20;
   logic [SW-1:0]    out_ch20;
   logic             out_valid20, out_ready20, sel_err20;

   logic [W-1:0] data_arr [N];

   always_comb begin
      in_data = '0;
      for (int i = 0; i < N; i++) in_data[i*W +: W] = data_arr[i];
   end

   always_comb begin
      in_data20 = '0;
      for (int i = 0; i < N20; i++) in_data20[i*W +: W] = data_arr[i];
   end

   mux_rr_nx1_reg #(.WIDTH(W), .NUM_CH(N), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .sel_err(sel_err)
   );

   mux_rr_nx1_reg #(.WIDTH(W), .NUM_CH(N20), .SEL_W(SW)) dut20 (
      .clk(clk), .rst(rst), .mode(1'b0), .sel(sel20),
      .in_data(in_data20), .in_valid(in_valid20), .in_ready(in_ready20),
      .out_data(out_data20), .out_ch(out_ch20), .out_valid(out_valid20),
      .out_ready(out_ready20), .sel_err(sel_err20)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Channel data pattern: 10..19, 110..119, 210..219, 310, 311
   function automatic logic [31:0] tbl(input int i);
      return 32'((i / 10) * 100 + 10 + (i % 10));
   endfunction

   // ---------------- reference model and scoreboard ----------------
   word_t sb_q[$];
   word_t log_q[$];
   int    mdl_ptr = 0;
   int    mon_g;
   bit    mon_ld;
   logic [N-1:0] mon_exp_rdy;

   function automatic int mdl_grant();
      if (!mode) begin
         if (int'(sel) < N && in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int off = 0; off < N; off++) begin
         if (in_valid[(mdl_ptr + off) % N]) return (mdl_ptr + off) % N;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         mdl_ptr = 0;
      end else begin
         check("out_valid", out_valid, sb_q.size() != 0);
         mon_ld = (sb_q.size() == 0) || out_ready;
         if (sb_q.size() != 0) begin
            check("out_data", out_data, sb_q[0].data);
            check("out_ch", out_ch, sb_q[0].ch);
            if (out_ready) log_q.push_back(sb_q.pop_front());
         end
         mon_g       = mdl_grant();
         mon_exp_rdy = (mon_g >= 0 && mon_ld) ? (N'(1) << mon_g) : '0;
         check("in_ready", in_ready, mon_exp_rdy);
         check("sel_err", sel_err, 1'b0);
         if (mon_g >= 0 && mon_ld) begin
            sb_q.push_back('{ch: mon_g, data: data_arr[mon_g]});
            if (mode) mdl_ptr = (mon_g + 1) % N;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = '0;
      out_ready = 1'b1;
      repeat (3) step();
   endtask

   task automatic check_log_ch(input string tag, input int idx, input int exp_ch);
      if (idx < log_q.size()) check(tag, log_q[idx].ch, exp_ch);
      else check({tag, "_missing"}, log_q.size(), idx + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      mode        = 1'b0;
      sel         = '0;
      in_valid    = '1;
      out_ready   = 1'b1;
      sel20       = '0;
      in_valid20  = '0;
      out_ready20 = 1'b1;
      for (int i = 0; i < N; i++) data_arr[i] = tbl(i);

      // Reset state: ready must be held low even with every input valid.
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, '0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_ch", out_ch, '0);
      in_valid = '0;
      rst      = 1'b0;
      step();

      // Direct basic: step sel through every channel.
      mode     = 1'b0;
      in_valid = '1;
      for (int k = 0; k < N; k++) begin
         sel = SW'(k);
         step();
      end
      drain();
      check("dir_cnt", log_q.size(), N);
      for (int k = 0; k < N; k++) begin
         if (k < log_q.size()) begin
            check($sformatf("dir_ch%0d", k), log_q[k].ch, k);
            check($sformatf("dir_data%0d", k), log_q[k].data, tbl(k));
         end
      end
      log_q.delete();

      // Backpressure: hold 15 while channel 5 changes to 99.
      sel         = 5;
      data_arr[5] = 15;
      in_valid    = '1;
      step();
      out_ready   = 1'b0;
      data_arr[5] = 99;
      for (int k = 0; k < 4; k++) begin
         step();
         check("bp_hold_data", out_data, 15);
         check("bp_hold_rdy", in_ready, '0);
         check("bp_hold_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      step();
      check("bp_next_data", out_data, 99);
      check("bp_next_ch", out_ch, 5);
      drain();
      if (log_q.size() >= 2) begin
         check("bp_log0", log_q[0].data, 15);
         check("bp_log1", log_q[1].data, 99);
      end else check("bp_log_cnt", log_q.size(), 2);
      data_arr[5] = tbl(5);
      log_q.delete();

      // Round-robin fairness with every channel valid.
      mode     = 1'b1;
      in_valid = '1;
      repeat (N + 1) step();
      drain();
      check("rr_cnt", log_q.size(), N + 1);
      for (int k = 0; k <= N; k++) check_log_ch($sformatf("rr_ch%0d", k), k, k % N);
      log_q.delete();

      // Only channels 2 and 5 valid, starting from ptr=3 (set by granting 2).
      in_valid = 32'h0000_0004;
      step();
      in_valid = 32'h0000_0024;
      repeat (4) step();
      drain();
      check_log_ch("rr25_pre", 0, 2);
      check_log_ch("rr25_0", 1, 5);
      check_log_ch("rr25_1", 2, 2);
      check_log_ch("rr25_2", 3, 5);
      check_log_ch("rr25_3", 4, 2);
      log_q.delete();

      // Out-of-range select on the NUM_CH=20 instance.
      in_valid20 = '1;
      sel20      = 3;
      step();
      sel20 = 25;
      #1;
      check("oor_sel_err", sel_err20, 1'b1);
      check("oor_rdy", in_ready20, '0);
      check("oor_pending", out_valid20, 1'b1);
      check("oor_pending_data", out_data20, tbl(3));
      step();
      check("oor_drained", out_valid20, 1'b0);
      check("oor_keep_data", out_data20, tbl(3));
      check("oor_keep_ch", out_ch20, 3);
      check("oor_rdy2", in_ready20, '0);
      sel20 = 4;
      #1;
      check("oor_sel_ok", sel_err20, 1'b0);
      in_valid20 = '0;

      // Mode switch: ptr=4, two direct transfers of channel 9, then resume at 4.
      mode     = 1'b1;
      in_valid = 32'h0000_0008;
      step();
      mode     = 1'b0;
      sel      = 9;
      in_valid = '1;
      repeat (2) step();
      mode = 1'b1;
      step();
      drain();
      check_log_ch("ms_pre", 0, 3);
      check_log_ch("ms_0", 1, 9);
      check_log_ch("ms_1", 2, 9);
      check_log_ch("ms_2", 3, 4);
      check("ms_cnt", log_q.size(), 4);
      log_q.delete();

      // Reset mid-hold with ptr=7.
      mode     = 1'b1;
      in_valid = 32'h0000_0040;
      step();
      out_ready = 1'b0;
      in_valid  = '1;
      step();
      check("mr_held_valid", out_valid, 1'b1);
      check("mr_held_ch", out_ch, 6);
      #2;
      rst = 1'b1;
      #1;
      check("mr_valid", out_valid, 1'b0);
      check("mr_data", out_data, '0);
      check("mr_ch", out_ch, '0);
      check("mr_rdy", in_ready, '0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      step();
      drain();
      check_log_ch("mr_first", 0, 0);
      log_q.delete();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
